lcd_bus_sched: RTL and testbench

- Sequences HD44780-style character-LCD bus cycles (lcd_data, lcd_rs, lcd_rw, lcd_en) for the mips789 system.
- Sits between the CPU memory-mapped LCD write port and the board LCD pins.
- Buffers CPU writes in a small FIFO and replays each one as a timed write cycle.
- The CPU never bit-bangs LCD timing.

---
 rtl/lcd_bus_sched.sv | 214 +++++++++++++++++++++
 tb/tb_lcd_bus_sched.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_sched.sv
// lcd_bus_sched: queues CPU writes for an HD44780-style character LCD and replays each as a timed bus cycle.
// Define LCD_INIT_SEQ_EN to issue the power-on sequence 0x38, 0x0C, 0x06, 0x01 before serving the FIFO.
module lcd_bus_sched #(
    parameter int FIFO_DEPTH = 8,
    parameter int SETUP_CYC  = 2,
    parameter int PULSE_CYC  = 12,
    parameter int HOLD_CYC   = 2,
    parameter int EXEC_CYC   = 2000,
    parameter int LONG_CYC   = 80000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [8:0] wr_data,
    input  logic       clr_err,
    output logic       full,
    output logic       empty,
    output logic       idle,
    output logic       ovf_err,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [16:0]  SETUP_LD = 17'(SETUP_CYC - 1);
    localparam logic [16:0]  PULSE_LD = 17'(PULSE_CYC - 1);
    localparam logic [16:0]  HOLD_LD  = 17'(HOLD_CYC - 1);
    localparam logic [16:0]  EXEC_LD  = 17'(EXEC_CYC - 1);
    localparam logic [16:0]  LONG_LD  = 17'(LONG_CYC - 1);

`ifdef LCD_INIT_SEQ_EN
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_INIT} state_t;
    localparam state_t RST_STATE = S_INIT;
    localparam logic   RST_IDLE  = 1'b0;
`else
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} state_t;
    localparam state_t RST_STATE = S_IDLE;
    localparam logic   RST_IDLE  = 1'b1;
`endif

    state_t      r_state, w_state_nx;
    logic [16:0] r_cnt, w_cnt_nx;
    logic [8:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0] r_count, w_count_nx;
    logic        r_full, r_empty, r_idle, r_ovf_err, w_ovf_nx;
    logic [7:0]  r_lcd_data, w_lcd_data_nx;
    logic        r_lcd_rs, w_lcd_rs_nx, r_lcd_en, w_lcd_en_nx;
    logic        r_long, w_long_nx;
    logic        w_push, w_pop, w_idle_nx;
    logic [8:0]  w_head;

`ifdef LCD_INIT_SEQ_EN
    logic [1:0] r_init_idx, w_init_idx_nx;
    logic       r_in_init, w_in_init_nx;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h06;
            default: init_byte = 8'h01;
        endcase
    endfunction
`endif

    assign w_push = wr_en && !r_full;
    assign w_head = r_mem[r_rd_ptr];

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_lcd_data_nx = r_lcd_data;
        w_lcd_rs_nx   = r_lcd_rs;
        w_long_nx     = r_long;
        w_pop         = 1'b0;
`ifdef LCD_INIT_SEQ_EN
        w_init_idx_nx = r_init_idx;
        w_in_init_nx  = r_in_init;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_empty) begin
                    w_pop         = 1'b1;
                    w_lcd_rs_nx   = w_head[8];
                    w_lcd_data_nx = w_head[7:0];
                    w_long_nx     = !w_head[8] && (w_head[7:2] == 6'd0);
                    w_cnt_nx      = SETUP_LD;
                    w_state_nx    = S_SETUP;
                end
            end
`ifdef LCD_INIT_SEQ_EN
            S_INIT: begin
                w_lcd_rs_nx   = 1'b0;
                w_lcd_data_nx = init_byte(r_init_idx);
                w_long_nx     = (r_init_idx == 2'd3);
                w_cnt_nx      = SETUP_LD;
                w_state_nx    = S_SETUP;
            end
`endif
            S_SETUP: begin
                w_cnt_nx = r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    w_cnt_nx   = PULSE_LD;
                    w_state_nx = S_PULSE;
                end
            end
            S_PULSE: begin
                w_cnt_nx = r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    w_cnt_nx   = HOLD_LD;
                    w_state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                w_cnt_nx = r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    w_cnt_nx   = r_long ? LONG_LD : EXEC_LD;
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_nx = r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_IDLE;
`ifdef LCD_INIT_SEQ_EN
                    // The last init byte hands over to the FIFO; earlier ones fetch the next ROM byte.
                    if (r_in_init) begin
                        if (r_init_idx == 2'd3) begin
                            w_in_init_nx = 1'b0;
                        end else begin
                            w_init_idx_nx = r_init_idx + 1'b1;
                            w_state_nx    = S_INIT;
                        end
                    end
`endif
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_count_nx = r_count;
        if (w_push && !w_pop)
            w_count_nx = r_count + 1'b1;
        else if (!w_push && w_pop)
            w_count_nx = r_count - 1'b1;
    end

    // Overflow set takes priority over a same-cycle clear.
    assign w_ovf_nx    = (wr_en && r_full) ? 1'b1 : (clr_err ? 1'b0 : r_ovf_err);
    assign w_lcd_en_nx = (w_state_nx == S_PULSE);
    assign w_idle_nx   = (w_state_nx == S_IDLE) && (w_count_nx == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RST_STATE;
            r_cnt      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_idle     <= RST_IDLE;
            r_ovf_err  <= 1'b0;
            r_lcd_data <= '0;
            r_lcd_rs   <= 1'b0;
            r_lcd_en   <= 1'b0;
            r_long     <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
            r_init_idx <= '0;
            r_in_init  <= 1'b1;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count    <= w_count_nx;
            r_full     <= (w_count_nx == FULL_CNT);
            r_empty    <= (w_count_nx == '0);
            r_idle     <= w_idle_nx;
            r_ovf_err  <= w_ovf_nx;
            r_lcd_data <= w_lcd_data_nx;
            r_lcd_rs   <= w_lcd_rs_nx;
            r_lcd_en   <= w_lcd_en_nx;
            r_long     <= w_long_nx;
`ifdef LCD_INIT_SEQ_EN
            r_init_idx <= w_init_idx_nx;
            r_in_init  <= w_in_init_nx;
`endif
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    assign full     = r_full;
    assign empty    = r_empty;
    assign idle     = r_idle;
    assign ovf_err  = r_ovf_err;
    assign lcd_data = r_lcd_data;
    assign lcd_rs   = r_lcd_rs;
    assign lcd_rw   = 1'b0;
    assign lcd_en   = r_lcd_en;
endmodule

// File: tb/tb_lcd_bus_sched.sv
// Self-checking bench for lcd_bus_sched: a scoreboard of expected {rs,data} words is popped on each lcd_en pulse.
// Build with LCD_INIT_SEQ_EN defined to also exercise the power-on init sequence.
module tb_lcd_bus_sched;
    localparam int DEPTH = 4;
    localparam int SETUP = 2;
    localparam int PULSE = 4;
    localparam int HOLD  = 2;
    localparam int EXEC  = 10;
    localparam int LONG  = 50;
    // Rise-to-rise spacing: strobe cycles, then the wait, then the single IDLE cycle before the next pop.
    localparam int PERIOD_NORM = SETUP + PULSE + HOLD + EXEC + 1;
    localparam int PERIOD_LONG = SETUP + PULSE + HOLD + LONG + 1;
`ifdef LCD_INIT_SEQ_EN
    localparam logic EXP_RST_IDLE = 1'b0;
`else
    localparam logic EXP_RST_IDLE = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [8:0] wr_data = '0;
    logic       clr_err = 1'b0;
    logic       full, empty, idle, ovf_err;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en;

    int n_checks = 0;
    int n_errors = 0;
    logic [8:0] sb_q[$];

    int   cyc = 0;
    int   pulse_cnt = 0;
    int   rise_cyc = 0;
    int   prev_rise_cyc = 0;
    logic prev_en = 1'b0;
    logic cut = 1'b0;
    logic rw_high = 1'b0;
    logic [8:0] mon_exp;
    logic [8:0] mon_rise_w;

    always #5 clk = ~clk;

    lcd_bus_sched #(
        .FIFO_DEPTH(DEPTH), .SETUP_CYC(SETUP), .PULSE_CYC(PULSE),
        .HOLD_CYC(HOLD), .EXEC_CYC(EXEC), .LONG_CYC(LONG)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr_err(clr_err),
        .full(full), .empty(empty), .idle(idle), .ovf_err(ovf_err),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
    );

    // Bus monitor: each rising lcd_en pops the scoreboard; each uninterrupted pulse is width- and stability-checked.
    always @(negedge clk) begin
        cyc++;
        if (lcd_rw !== 1'b0) rw_high = 1'b1;
        if (rst) cut = 1'b1;
        if (lcd_en === 1'b1 && prev_en !== 1'b1) begin
            prev_rise_cyc = rise_cyc;
            rise_cyc      = cyc;
            pulse_cnt++;
            cut           = rst;
            mon_rise_w    = {lcd_rs, lcd_data};
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL pulse_unexpected: got rs=%0b data=%02h, required no pulse", lcd_rs, lcd_data);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({lcd_rs, lcd_data} !== mon_exp) begin
                    n_errors++;
                    $display("FAIL pulse_word: got %03h, required %03h", {lcd_rs, lcd_data}, mon_exp);
                end
            end
        end
        if (lcd_en === 1'b0 && prev_en === 1'b1 && !cut) begin
            n_checks++;
            if (cyc - rise_cyc != PULSE) begin
                n_errors++;
                $display("FAIL pulse_width: got %0d cycles, required %0d", cyc - rise_cyc, PULSE);
            end
            n_checks++;
            if ({lcd_rs, lcd_data} !== mon_rise_w) begin
                n_errors++;
                $display("FAIL bus_stable: got %03h at fall, required %03h", {lcd_rs, lcd_data}, mon_rise_w);
            end
        end
        prev_en = lcd_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_init_words();
`ifdef LCD_INIT_SEQ_EN
        sb_q.push_back(9'h038);
        sb_q.push_back(9'h00C);
        sb_q.push_back(9'h006);
        sb_q.push_back(9'h001);
`endif
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (idle === 1'b1) break;
            tick();
        end
        n_checks++;
        if (idle !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_idle_timeout: got idle=%0b after %0d cycles, required 1", name, idle, budget);
        end
    endtask

    task automatic wait_pulses(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (pulse_cnt >= target) break;
            tick();
        end
        n_checks++;
        if (pulse_cnt < target) begin
            n_errors++;
            $display("FAIL %s_pulse_timeout: got %0d pulses, required %0d", name, pulse_cnt, target);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        push_init_words();
`ifdef LCD_INIT_SEQ_EN
        wait_idle(400, "reset_init");
`endif
    endtask

    task automatic write_word(input logic [8:0] d, input logic accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) sb_q.push_back(d);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_checks += 8;
        if (lcd_data !== 8'h00) begin n_errors++; $display("FAIL rst_lcd_data: got %02h, required 00", lcd_data); end
        if (lcd_rs !== 1'b0)    begin n_errors++; $display("FAIL rst_lcd_rs: got %0b, required 0", lcd_rs); end
        if (lcd_rw !== 1'b0)    begin n_errors++; $display("FAIL rst_lcd_rw: got %0b, required 0", lcd_rw); end
        if (lcd_en !== 1'b0)    begin n_errors++; $display("FAIL rst_lcd_en: got %0b, required 0", lcd_en); end
        if (full !== 1'b0)      begin n_errors++; $display("FAIL rst_full: got %0b, required 0", full); end
        if (empty !== 1'b1)     begin n_errors++; $display("FAIL rst_empty: got %0b, required 1", empty); end
        if (idle !== EXP_RST_IDLE) begin n_errors++; $display("FAIL rst_idle: got %0b, required %0b", idle, EXP_RST_IDLE); end
        if (ovf_err !== 1'b0)   begin n_errors++; $display("FAIL rst_ovf_err: got %0b, required 0", ovf_err); end
        rst = 1'b0;
        sb_q.delete();
        push_init_words();
`ifdef LCD_INIT_SEQ_EN
        wait_idle(400, "rst_init");
`endif
    endtask

    task automatic test_single_write();
        int p0;
        do_reset();
        write_word(9'h141, 1'b1);
        n_checks++;
        if (empty !== 1'b0) begin n_errors++; $display("FAIL single_empty: got %0b, required 0", empty); end
        tick();
        p0 = pulse_cnt;
        n_checks += 3;
        if (lcd_rs !== 1'b1)      begin n_errors++; $display("FAIL single_rs: got %0b, required 1", lcd_rs); end
        if (lcd_data !== 8'h41)   begin n_errors++; $display("FAIL single_data: got %02h, required 41", lcd_data); end
        if (lcd_en !== 1'b0)      begin n_errors++; $display("FAIL single_en_pop: got %0b, required 0", lcd_en); end
        tick();
        n_checks++;
        if (lcd_en !== 1'b0) begin n_errors++; $display("FAIL single_en_setup: got %0b, required 0", lcd_en); end
        tick();
        n_checks++;
        if (lcd_en !== 1'b1) begin n_errors++; $display("FAIL single_en_rise: got %0b, required 1", lcd_en); end
        repeat (15) tick();
        n_checks++;
        if (idle !== 1'b0) begin n_errors++; $display("FAIL single_idle_early: got %0b at pop+17, required 0", idle); end
        tick();
        n_checks += 2;
        if (idle !== 1'b1) begin n_errors++; $display("FAIL single_idle: got %0b at pop+18, required 1", idle); end
        if (pulse_cnt != p0 + 1) begin n_errors++; $display("FAIL single_pulse_count: got %0d, required %0d", pulse_cnt - p0, 1); end
    endtask

    task automatic test_long_command();
        int p0;
        p0 = pulse_cnt;
        rw_high = 1'b0;
        write_word(9'h001, 1'b1);
        write_word(9'h141, 1'b1);
        wait_pulses(p0 + 2, 300, "long");
        n_checks += 2;
        if (rise_cyc - prev_rise_cyc != PERIOD_LONG) begin
            n_errors++;
            $display("FAIL long_gap: got %0d cycles, required %0d", rise_cyc - prev_rise_cyc, PERIOD_LONG);
        end
        if (rw_high !== 1'b0) begin n_errors++; $display("FAIL long_rw: got lcd_rw=1 seen, required always 0"); end
        wait_idle(100, "long");
    endtask

    task automatic test_overflow();
        int p0;
        p0 = pulse_cnt;
        for (int i = 0; i < 6; i++) begin
            write_word(9'h130 + 9'(i), i < 5);
            if (i == 4) begin
                n_checks++;
                if (full !== 1'b1) begin n_errors++; $display("FAIL ovf_full: got %0b, required 1", full); end
            end
        end
        n_checks++;
        if (ovf_err !== 1'b1) begin n_errors++; $display("FAIL ovf_set: got %0b, required 1", ovf_err); end
        wait_pulses(p0 + 5, 5 * PERIOD_NORM + 50, "ovf");
        wait_idle(100, "ovf");
        n_checks += 2;
        if (pulse_cnt != p0 + 5) begin n_errors++; $display("FAIL ovf_pulse_count: got %0d, required 5", pulse_cnt - p0); end
        if (sb_q.size() != 0)    begin n_errors++; $display("FAIL ovf_sb_left: got %0d pending, required 0", sb_q.size()); end
    endtask

    task automatic test_err_clear_race();
        int p0;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_checks++;
        if (ovf_err !== 1'b0) begin n_errors++; $display("FAIL race_preclear: got %0b, required 0", ovf_err); end
        p0 = pulse_cnt;
        for (int i = 0; i < 5; i++) write_word(9'h150 + 9'(i), 1'b1);
        clr_err = 1'b1;
        write_word(9'h155, 1'b0);
        n_checks++;
        if (ovf_err !== 1'b1) begin n_errors++; $display("FAIL race_set_wins: got %0b, required 1", ovf_err); end
        tick();
        clr_err = 1'b0;
        n_checks++;
        if (ovf_err !== 1'b0) begin n_errors++; $display("FAIL race_clear: got %0b, required 0", ovf_err); end
        wait_pulses(p0 + 5, 5 * PERIOD_NORM + 50, "race");
        wait_idle(100, "race");
    endtask

    task automatic test_reset_mid_pulse();
        int p1;
        int extra;
        write_word(9'h160, 1'b1);
        write_word(9'h161, 1'b1);
        write_word(9'h162, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (lcd_en === 1'b1) break;
            tick();
        end
        n_checks += 2;
        if (lcd_en !== 1'b1) begin n_errors++; $display("FAIL mid_en_timeout: got %0b, required 1", lcd_en); end
        if (empty !== 1'b0)  begin n_errors++; $display("FAIL mid_queued: got empty=%0b, required 0", empty); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        n_checks += 5;
        if (lcd_en !== 1'b0)    begin n_errors++; $display("FAIL mid_en: got %0b, required 0", lcd_en); end
        if (empty !== 1'b1)     begin n_errors++; $display("FAIL mid_empty: got %0b, required 1", empty); end
        if (full !== 1'b0)      begin n_errors++; $display("FAIL mid_full: got %0b, required 0", full); end
        if (lcd_data !== 8'h00) begin n_errors++; $display("FAIL mid_data: got %02h, required 00", lcd_data); end
        if (lcd_rs !== 1'b0)    begin n_errors++; $display("FAIL mid_rs: got %0b, required 0", lcd_rs); end
        p1 = pulse_cnt;
        extra = 0;
        push_init_words();
`ifdef LCD_INIT_SEQ_EN
        extra = 4;
`endif
        repeat (3 * PERIOD_LONG) tick();
        n_checks += 2;
        if (pulse_cnt != p1 + extra) begin n_errors++; $display("FAIL mid_no_pulse: got %0d pulses, required %0d", pulse_cnt - p1, extra); end
        if (idle !== 1'b1) begin n_errors++; $display("FAIL mid_idle: got %0b, required 1", idle); end
    endtask

`ifdef LCD_INIT_SEQ_EN
    task automatic test_init_seq();
        int p0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        push_init_words();
        p0 = pulse_cnt;
        write_word(9'h141, 1'b1);
        n_checks++;
        if (idle !== 1'b0) begin n_errors++; $display("FAIL init_idle: got %0b, required 0", idle); end
        wait_pulses(p0 + 5, 500, "init");
        n_checks++;
        if (rise_cyc - prev_rise_cyc != PERIOD_LONG) begin
            n_errors++;
            $display("FAIL init_gap: got %0d cycles, required %0d", rise_cyc - prev_rise_cyc, PERIOD_LONG);
        end
        wait_idle(100, "init");
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_long_command();
        test_overflow();
        test_err_clear_race();
        test_reset_mid_pulse();
`ifdef LCD_INIT_SEQ_EN
        test_init_seq();
`endif
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d pending words, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
